// File: rtl/vlsu_mem_sched.sv
// Direction scheduler for the VLSU memory port: serialises read/write address phases,
// drains in-flight bursts before each switch and bounds per-phase runs.
module vlsu_mem_sched #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned MaxRun         = 4,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  input  logic            r_valid_i,
  input  logic            r_ready_i,
  input  logic            r_last_i,
  input  logic            b_valid_i,
  input  logic            b_ready_i,
  output logic [CntW-1:0] rd_outstanding_o,
  output logic [CntW-1:0] wr_outstanding_o,
  output logic [2:0]      state_o,
  output logic            idle_o,
  output logic            cnt_err_o
);

  localparam int unsigned RunW = $clog2(MaxRun + 1);
  localparam logic [CntW-1:0] MaxOutCnt = CntW'(MaxOutstanding);
  localparam logic [RunW-1:0] MaxRunCnt = RunW'(MaxRun);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DRAIN_R = 3'd3,
    ST_DRAIN_W = 3'd4
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RunW-1:0] run_cnt_q;
  logic            ar_hold_q, aw_hold_q;
  logic            last_wr_q;
  logic            cnt_err_q;
  logic            rd_err, wr_err;
  logic            rd_grant, wr_grant;
  logic            ar_hs, aw_hs, r_done, b_done;
  logic            run_full;

  assign run_full = (run_cnt_q == MaxRunCnt);

  // A pending hold keeps its grant regardless of state so a raised valid is never withdrawn.
  assign rd_grant = ar_hold_q | ((state_q == ST_READ) & (rd_cnt_q < MaxOutCnt) &
                                 !(aw_valid_i & run_full));
  assign wr_grant = aw_hold_q | ((state_q == ST_WRITE) & (wr_cnt_q < MaxOutCnt) &
                                 !(ar_valid_i & run_full));

  assign ar_valid_o = ar_valid_i & rd_grant;
  assign ar_ready_o = ar_ready_i & rd_grant;
  assign aw_valid_o = aw_valid_i & wr_grant;
  assign aw_ready_o = aw_ready_i & wr_grant;

  assign ar_hs  = ar_valid_o & ar_ready_i;
  assign aw_hs  = aw_valid_o & aw_ready_i;
  assign r_done = r_valid_i & r_ready_i & r_last_i;
  assign b_done = b_valid_i & b_ready_i;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_err   = 1'b0;
    if (ar_hs && !r_done) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end else if (!ar_hs && r_done) begin
      if (rd_cnt_q == '0) rd_err = 1'b1;
      else                rd_cnt_d = rd_cnt_q - 1'b1;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_err   = 1'b0;
    if (aw_hs && !b_done) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end else if (!aw_hs && b_done) begin
      if (wr_cnt_q == '0) wr_err = 1'b1;
      else                wr_cnt_d = wr_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      run_cnt_q <= '0;
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
      last_wr_q <= 1'b1;
      cnt_err_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      cnt_err_q <= cnt_err_q | rd_err | wr_err;
      if (ar_hs)                         ar_hold_q <= 1'b0;
      else if (ar_valid_o && !ar_ready_i) ar_hold_q <= 1'b1;
      if (aw_hs)                         aw_hold_q <= 1'b0;
      else if (aw_valid_o && !aw_ready_i) aw_hold_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          // Simultaneous requests go to the direction that did not run last.
          if (ar_valid_i && (!aw_valid_i || last_wr_q)) begin
            state_q   <= ST_READ;
            run_cnt_q <= '0;
          end else if (aw_valid_i) begin
            state_q   <= ST_WRITE;
            run_cnt_q <= '0;
          end
        end
        ST_READ: begin
          last_wr_q <= 1'b0;
          if (ar_hs && !run_full) run_cnt_q <= run_cnt_q + 1'b1;
          if (aw_valid_i && !ar_hold_q && (run_full || !ar_valid_i))
            state_q <= ST_DRAIN_R;
          else if (!ar_valid_i && !aw_valid_i && !ar_hold_q && rd_cnt_q == '0)
            state_q <= ST_IDLE;
        end
        ST_WRITE: begin
          last_wr_q <= 1'b1;
          if (aw_hs && !run_full) run_cnt_q <= run_cnt_q + 1'b1;
          if (ar_valid_i && !aw_hold_q && (run_full || !aw_valid_i))
            state_q <= ST_DRAIN_W;
          else if (!ar_valid_i && !aw_valid_i && !aw_hold_q && wr_cnt_q == '0)
            state_q <= ST_IDLE;
        end
        ST_DRAIN_R: begin
          if (rd_cnt_q == '0) begin
            state_q   <= ST_WRITE;
            run_cnt_q <= '0;
          end
        end
        ST_DRAIN_W: begin
          if (wr_cnt_q == '0) begin
            state_q   <= ST_READ;
            run_cnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_outstanding_o = rd_cnt_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign state_o          = state_q;
  assign idle_o           = (state_q == ST_IDLE) && (rd_cnt_q == '0) && (wr_cnt_q == '0);
  assign cnt_err_o        = cnt_err_q;

endmodule

// File: tb/tb_vlsu_mem_sched.sv
// Directed bench for vlsu_mem_sched: single load, run limit, saturation, hold,
// simultaneous count events, error flag and asynchronous reset.
module tb_vlsu_mem_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ar_valid_i, ar_ready_o, aw_valid_i, aw_ready_o;
  logic       ar_valid_o, ar_ready_i, aw_valid_o, aw_ready_i;
  logic       r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
  logic [3:0] rd_out, wr_out;
  logic [2:0] state_o;
  logic       idle_o, cnt_err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] st_log [0:31];
  logic [3:0] rd_log [0:31];
  bit         arh_log[0:31];
  bit         awh_log[0:31];
  bit         r_due  [0:47];
  bit         b_due  [0:47];

  vlsu_mem_sched #(.MaxOutstanding(8), .MaxRun(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out),
    .state_o(state_o), .idle_o(idle_o), .cnt_err_o(cnt_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ar_valid_i = 0; ar_ready_i = 0; aw_valid_i = 0; aw_ready_i = 0;
    r_valid_i = 0; r_ready_i = 0; r_last_i = 0; b_valid_i = 0; b_ready_i = 0;
  endtask

  task automatic set_r(input bit v);
    r_valid_i = v; r_ready_i = v; r_last_i = v;
  endtask

  task automatic set_b(input bit v);
    b_valid_i = v; b_ready_i = v;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cyc();
  endtask

  initial begin
    int na, nw;

    // Reset state
    do_reset();
    #1;
    check("rst_state", 32'(state_o), 0);
    check("rst_idle", 32'(idle_o), 1);
    check("rst_ar_valid", 32'(ar_valid_o), 0);
    check("rst_ar_ready", 32'(ar_ready_o), 0);
    check("rst_aw_valid", 32'(aw_valid_o), 0);
    check("rst_rd_cnt", 32'(rd_out), 0);
    check("rst_err", 32'(cnt_err_o), 0);

    // Single load: one-cycle arbitration bubble, then grant
    ar_valid_i = 1; ar_ready_i = 1;
    #1;
    check("load_bubble", 32'(ar_valid_o), 0);
    cyc(); #1;
    check("load_state", 32'(state_o), 1);
    check("load_ar_valid", 32'(ar_valid_o), 1);
    cyc();
    ar_valid_i = 0;
    #1;
    check("load_rd_cnt1", 32'(rd_out), 1);
    set_r(1);
    cyc();
    set_r(0);
    #1;
    check("load_rd_cnt0", 32'(rd_out), 0);
    cyc(); #1;
    check("load_back_idle", 32'(state_o), 0);
    check("load_idle_o", 32'(idle_o), 1);

    // Run limit: continuous AR and AW, completions 3 cycles after each address
    do_reset();
    for (int i = 0; i < 48; i++) begin r_due[i] = 0; b_due[i] = 0; end
    ar_valid_i = 1; ar_ready_i = 1; aw_valid_i = 1; aw_ready_i = 1;
    for (int t = 0; t < 18; t++) begin
      set_r(r_due[t]);
      set_b(b_due[t]);
      #1;
      st_log[t]  = state_o;
      rd_log[t]  = rd_out;
      arh_log[t] = ar_valid_o & ar_ready_i;
      awh_log[t] = aw_valid_o & aw_ready_i;
      if (arh_log[t]) r_due[t+3] = 1;
      if (awh_log[t]) b_due[t+3] = 1;
      cyc();
    end
    idle_inputs();
    na = 0; nw = 0;
    for (int t = 0; t < 9; t++) begin na += int'(arh_log[t]); nw += int'(awh_log[t]); end
    check("run_ar_hs_phase1", 32'(na), 4);
    check("run_aw_hs_phase1", 32'(nw), 0);
    check("run_state_c5", 32'(st_log[5]), 1);
    check("run_state_c6", 32'(st_log[6]), 3);
    check("run_rd_cnt_c8", 32'(rd_log[8]), 0);
    check("run_state_c8", 32'(st_log[8]), 3);
    check("run_state_c9", 32'(st_log[9]), 2);
    na = 0; nw = 0;
    for (int t = 9; t < 17; t++) begin na += int'(arh_log[t]); nw += int'(awh_log[t]); end
    check("run_aw_hs_phase2", 32'(nw), 4);
    check("run_ar_hs_phase2", 32'(na), 0);
    check("run_state_c14", 32'(st_log[14]), 4);
    check("run_state_c17", 32'(st_log[17]), 1);
    check("run_ar_hs_c17", 32'(arh_log[17]), 1);

    // Saturation at 8 outstanding reads
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    for (int i = 0; i < 9; i++) cyc();
    #1;
    check("sat_rd_cnt", 32'(rd_out), 8);
    check("sat_ar_ready", 32'(ar_ready_o), 0);
    set_r(1);
    #1;
    check("sat_ar_ready_same", 32'(ar_ready_o), 0);
    cyc();
    set_r(0);
    #1;
    check("sat_rd_cnt7", 32'(rd_out), 7);
    check("sat_regrant", 32'(ar_ready_o), 1);
    cyc(); #1;
    check("sat_rd_cnt_back8", 32'(rd_out), 8);

    // Hold stability: AR stalled while AW arrives at run_cnt=3
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    for (int i = 0; i < 4; i++) cyc();
    ar_ready_i = 0; aw_valid_i = 1; aw_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_ar_valid", 32'(ar_valid_o), 1);
      check("hold_state", 32'(state_o), 1);
      cyc();
    end
    ar_ready_i = 1;
    #1;
    check("hold_accept", 32'(ar_valid_o), 1);
    cyc(); #1;
    check("hold_post_valid", 32'(ar_valid_o), 0);
    check("hold_rd_cnt", 32'(rd_out), 4);
    cyc(); #1;
    check("hold_drain", 32'(state_o), 3);

    // ar_hs and r_done together at count 2
    do_reset();
    ar_valid_i = 1; ar_ready_i = 1;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    check("simul_pre", 32'(rd_out), 2);
    set_r(1);
    cyc();
    set_r(0); ar_valid_i = 0;
    #1;
    check("simul_post", 32'(rd_out), 2);

    // B completion with nothing outstanding
    do_reset();
    set_b(1);
    cyc();
    set_b(0);
    #1;
    check("err_set", 32'(cnt_err_o), 1);
    check("err_wr_cnt", 32'(wr_out), 0);
    for (int i = 0; i < 3; i++) cyc();
    check("err_sticky", 32'(cnt_err_o), 1);
    #1;
    rst_n = 0;
    #1;
    check("err_cleared", 32'(cnt_err_o), 0);
    rst_n = 1;

    // Asynchronous reset mid-WRITE with 3 outstanding
    do_reset();
    aw_valid_i = 1; aw_ready_i = 1;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    check("areset_pre_state", 32'(state_o), 2);
    check("areset_pre_wr", 32'(wr_out), 3);
    rst_n = 0;
    #1;
    check("areset_state", 32'(state_o), 0);
    check("areset_wr", 32'(wr_out), 0);
    check("areset_aw_valid", 32'(aw_valid_o), 0);
    check("areset_aw_ready", 32'(aw_ready_o), 0);
    check("areset_idle", 32'(idle_o), 1);
    idle_inputs();
    rst_n = 1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
